// File: rtl/filtered_image_reader.sv
// Streams the filtered image out of filteredimage_ram in raster order on a valid/ready
// stream with sol/eol/eof markers; a 2-entry prefetch buffer hides the 1-cycle RAM latency.
module filtered_image_reader #(
   parameter int IMG_W  = 254,
   parameter int IMG_H  = 254,
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [7:0]        rd_data,
   output logic [7:0]        px_data,
   output logic              px_valid,
   input  logic              px_ready,
   output logic              px_sol,
   output logic              px_eol,
   output logic              px_eof,
   output logic              done
);

   localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);

   typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

   typedef struct packed {
      logic sol;
      logic eol;
      logic eof;
   } flg_t;

   typedef struct packed {
      logic [7:0] data;
      flg_t       flg;
   } ent_t;

   state_t        state, state_nxt;
   logic [XW-1:0] x;
   logic [YW-1:0] y;
   flg_t          iss_flg, infl_flg;
   logic          infl;
   ent_t          e0, e1, new_ent;
   logic          v0, v1;
   logic          pop, push, frame_end;

   // Head entry is a plain register so the stream outputs never see px_ready.
   assign px_data  = e0.data;
   assign px_sol   = e0.flg.sol;
   assign px_eol   = e0.flg.eol;
   assign px_eof   = e0.flg.eof;
   assign px_valid = v0;

   always_comb begin
      pop         = v0 & px_ready;
      push        = infl;
      new_ent     = '{data: rd_data, flg: infl_flg};
      iss_flg.sol = (x == '0);
      iss_flg.eol = (x == XW'(IMG_W - 1));
      iss_flg.eof = iss_flg.eol && (y == YW'(IMG_H - 1));
      frame_end   = (state == DRAIN) && pop && e0.flg.eof;
      rd_en       = 1'b0;
      state_nxt   = state;
      case (state)
         IDLE: if (start) state_nxt = READ;
         READ: begin
            // Occupancy + in-flight below 2, or a slot frees up this cycle.
            rd_en = !(v1 | (v0 & infl)) | pop;
            if (rd_en && rd_addr == LAST_ADDR) state_nxt = DRAIN;
         end
         DRAIN: if (frame_end) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         rd_addr  <= '0;
         x        <= '0;
         y        <= '0;
         infl     <= 1'b0;
         infl_flg <= '0;
         e0       <= '0;
         e1       <= '0;
         v0       <= 1'b0;
         v1       <= 1'b0;
      end else begin
         state <= state_nxt;
         done  <= frame_end;
         infl  <= rd_en;
         if (state == IDLE && start) begin
            busy    <= 1'b1;
            rd_addr <= '0;
            x       <= '0;
            y       <= '0;
         end
         if (frame_end) begin
            busy    <= 1'b0;
            rd_addr <= '0;
         end
         if (rd_en) begin
            rd_addr  <= rd_addr + ADDR_W'(1);
            infl_flg <= iss_flg;
            if (iss_flg.eol) begin
               x <= '0;
               y <= iss_flg.eof ? '0 : y + YW'(1);
            end else begin
               x <= x + XW'(1);
            end
         end
         case ({push, pop})
            2'b10: begin
               if (!v0) begin
                  e0 <= new_ent;
                  v0 <= 1'b1;
               end else begin
                  e1 <= new_ent;
                  v1 <= 1'b1;
               end
            end
            2'b01: begin
               e0 <= e1;
               v0 <= v1;
               v1 <= 1'b0;
            end
            2'b11: begin
               if (v1) begin
                  e0 <= e1;
                  e1 <= new_ent;
               end else begin
                  e0 <= new_ent;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_filtered_image_reader.sv
// Scoreboard bench for filtered_image_reader: a 4x3 frame under several ready patterns,
// start-while-busy, mid-frame reset, and a 1x2 frame.
module tb_filtered_image_reader;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0, px_ready = 1'b1;
   logic        busy, rd_en, px_valid, px_sol, px_eol, px_eof, done;
   logic [15:0] rd_addr;
   logic [7:0]  rd_data = '0, px_data;

   logic        b_start = 1'b0, b_ready = 1'b1;
   logic        b_busy, b_rd_en, b_valid, b_sol, b_eol, b_eof, b_done;
   logic [15:0] b_addr;
   logic [7:0]  b_rd_data = '0, b_data;

   int          nchk = 0, nerr = 0;
   int          cyc = 0, t0 = 0, bt0 = 0;
   int          nbeat = 0, ndone = 0, donecyc = 0, nbdone = 0, bdonecyc = 0;
   int          iss = 0, acc = 0;
   logic        prev_hold = 1'b0, rd_cnt_en = 1'b0;
   logic [11:0] prev_vec = '0;
   logic [10:0] q[$], qb[$];
   logic [15:0] rd_log[$];

   filtered_image_reader #(.IMG_W(4), .IMG_H(3), .ADDR_W(16)) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_data(rd_data), .px_data(px_data), .px_valid(px_valid), .px_ready(px_ready),
      .px_sol(px_sol), .px_eol(px_eol), .px_eof(px_eof), .done(done));

   filtered_image_reader #(.IMG_W(1), .IMG_H(2), .ADDR_W(16)) dut_b (
      .clk(clk), .rst(rst), .start(b_start), .busy(b_busy), .rd_en(b_rd_en), .rd_addr(b_addr),
      .rd_data(b_rd_data), .px_data(b_data), .px_valid(b_valid), .px_ready(b_ready),
      .px_sol(b_sol), .px_eol(b_eol), .px_eof(b_eof), .done(b_done));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // RAM models: data = addr + 16, one cycle after the strobe.
   always @(posedge clk) begin
      if (rd_en)   rd_data   <= rd_addr[7:0] + 8'd16;
      if (b_rd_en) b_rd_data <= b_addr[7:0] + 8'd16;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [30:0] outs_vec();
      return {busy, rd_en, rd_addr, px_data, px_valid, px_sol, px_eol, px_eof, done};
   endfunction

   always @(negedge clk) begin
      if (!rst) begin
         iss = 0;
         acc = 0;
         prev_hold = 1'b0;
      end else begin
         if (prev_hold)
            check("hold_stable", {px_valid, px_data, px_sol, px_eol, px_eof}, prev_vec);
         prev_hold = px_valid & !px_ready;
         prev_vec  = {px_valid, px_data, px_sol, px_eol, px_eof};
         if (rd_en) begin
            iss++;
            if (rd_cnt_en) rd_log.push_back(rd_addr);
         end
         if (px_valid && px_ready) begin
            acc++;
            nbeat++;
            if (q.size() == 0) check("extra_beat", {px_data, px_sol, px_eol, px_eof}, 0);
            else check("beat", {px_data, px_sol, px_eol, px_eof}, q.pop_front());
         end
         check("occupancy_le2", 32'((iss - acc) <= 2), 1);
         if (done) begin
            ndone++;
            donecyc = cyc;
         end
         if (b_valid && b_ready) begin
            if (qb.size() == 0) check("b_extra_beat", {b_data, b_sol, b_eol, b_eof}, 0);
            else check("b_beat", {b_data, b_sol, b_eol, b_eof}, qb.pop_front());
         end
         if (b_done) begin
            nbdone++;
            bdonecyc = cyc;
         end
      end
   end

   task automatic push_frame();
      for (int a = 0; a < 12; a++)
         q.push_back({8'(a + 16), a % 4 == 0, a % 4 == 3, a == 11});
   endtask

   // Called in the posedge+1 phase; returns in the same phase with t0 = cycle of E0.
   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      t0 = cyc;
   endtask

   task automatic wait_done(input string tag, input int maxc);
      int d0 = ndone;
      for (int i = 0; i < maxc && ndone == d0; i++) @(posedge clk);
      #1;
      check(tag, 32'(ndone > d0), 1);
   endtask

   task automatic wait_beats(input int tgt);
      for (int i = 0; i < 100 && nbeat < tgt; i++) begin
         @(posedge clk); #1;
      end
      check("beat_reached", 32'(nbeat >= tgt), 1);
   endtask

   initial begin
      int d0;
      #3;
      check("reset_outs", 32'(outs_vec()), 0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      check("idle_outs", 32'(outs_vec()), 0);

      // Continuous ready: first-read timing and done latency.
      push_frame();
      pulse_start();
      @(negedge clk);
      check("start_busy_rd", {busy, rd_en, rd_addr}, {2'b11, 16'd0});
      @(posedge clk); #1;
      wait_done("t1_done", 40);
      check("t1_done_lat", 32'(donecyc - t0), 14);
      check("t1_busy_low", busy, 0);
      check("t1_q_empty", q.size(), 0);

      // Random ready.
      repeat (3) @(posedge clk);
      #1;
      push_frame();
      d0 = ndone;
      pulse_start();
      for (int i = 0; i < 300 && ndone == d0; i++) begin
         @(posedge clk); #1;
         px_ready = 1'($urandom_range(0, 1));
      end
      px_ready = 1'b1;
      check("t2_done", 32'(ndone - d0), 1);
      check("t2_q_empty", q.size(), 0);

      // Ready held low for 10 cycles: only two reads, then back-to-back beats.
      @(posedge clk); #1;
      px_ready = 1'b0;
      rd_log.delete();
      rd_cnt_en = 1'b1;
      push_frame();
      pulse_start();
      repeat (10) @(posedge clk);
      #1;
      rd_cnt_en = 1'b0;
      check("t3_rd_count", rd_log.size(), 2);
      if (rd_log.size() >= 2) begin
         check("t3_rd_addr0", rd_log[0], 0);
         check("t3_rd_addr1", rd_log[1], 1);
      end
      px_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         check("t3_b2b_valid", px_valid, 1);
      end
      @(posedge clk); #1;
      wait_done("t3_done", 20);
      check("t3_q_empty", q.size(), 0);

      // Start re-pulsed mid-frame is ignored.
      @(posedge clk); #1;
      push_frame();
      d0 = ndone;
      pulse_start();
      wait_beats(nbeat + 5);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (30) @(posedge clk);
      #1;
      check("t4_single_done", 32'(ndone - d0), 1);
      check("t4_done_lat", 32'(donecyc - t0), 14);
      check("t4_q_empty", q.size(), 0);
      check("t4_idle", busy, 0);

      // Reset mid-frame, then replay from address 0.
      push_frame();
      pulse_start();
      wait_beats(nbeat + 6);
      rst = 1'b0;
      #1;
      check("t5_reset_outs", 32'(outs_vec()), 0);
      q.delete();
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      push_frame();
      pulse_start();
      wait_done("t5_done", 40);
      check("t5_done_lat", 32'(donecyc - t0), 14);
      check("t5_q_empty", q.size(), 0);

      // 1x2 frame: every pixel is both sol and eol.
      qb.push_back({8'd16, 3'b110});
      qb.push_back({8'd17, 3'b111});
      d0 = nbdone;
      b_start = 1'b1;
      @(posedge clk); #1;
      b_start = 1'b0;
      bt0 = cyc;
      for (int i = 0; i < 20 && nbdone == d0; i++) @(posedge clk);
      #1;
      check("b_done", 32'(nbdone - d0), 1);
      check("b_done_lat", 32'(bdonecyc - bt0), 4);
      check("b_q_empty", qb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule
